// File: rtl/shift_operand_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : shift_operand_stage_if
// Brief    : Decode-to-EX handshake bundle for the shift operand stage.
// Revision : 1.0 - initial release
// ============================================================================
interface shift_operand_stage_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [5:0]         in_funct;
    logic [SHAMT_W-1:0] in_shamt;
    logic [WIDTH-1:0]   in_rs;
    logic [WIDTH-1:0]   in_rt;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_a;
    logic [WIDTH-1:0]   out_b;
    logic [1:0]         out_alufun;
    logic               out_illegal;

    modport master (
        output flush, in_valid, in_funct, in_shamt, in_rs, in_rt, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_alufun, out_illegal
    );

    modport slave (
        input  flush, in_valid, in_funct, in_shamt, in_rs, in_rt, out_ready,
        output in_ready, out_valid, out_a, out_b, out_alufun, out_illegal
    );
endinterface
`default_nettype wire

// File: rtl/shift_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : shift_operand_stage
// Brief    : EX front end for the barrel shifter: funct decode, shift-amount
//            select and a 2-entry skid buffer. Optional macro
//            SHIFT_STALL_CNT_EN adds a saturating stall_cnt output.
// Revision : 1.0 - initial release
// ============================================================================
module shift_operand_stage #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    shift_operand_stage_if.slave   bus
`ifdef SHIFT_STALL_CNT_EN
    ,
    output logic [31:0]            stall_cnt
`endif
);

    localparam logic [1:0] c_ST_EMPTY = 2'b00;
    localparam logic [1:0] c_ST_ONE   = 2'b01;
    localparam logic [1:0] c_ST_FULL  = 2'b11;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;

    logic [SHAMT_W-1:0] w_amt;
    logic [1:0]         w_fun;
    logic               w_ill;
    logic [WIDTH-1:0]   w_b;

    logic [WIDTH-1:0]   r_main_a;
    logic [WIDTH-1:0]   r_main_b;
    logic [1:0]         r_main_fun;
    logic               r_main_ill;
    logic [WIDTH-1:0]   r_skid_a;
    logic [WIDTH-1:0]   r_skid_b;
    logic [1:0]         r_skid_fun;
    logic               r_skid_ill;

    logic               w_accept;
    logic               w_xfer;
    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_load_main;
    logic               w_load_skid;
    logic               w_skid_to_main;

    // Only the low amount bits of rs feed the shifter.
    logic               w_unused_rs;
    assign w_unused_rs = ^bus.in_rs[WIDTH-1:SHAMT_W];

    // ------------------------------------------------------------------
    // Funct decode and amount select
    // ------------------------------------------------------------------
    always_comb begin
        w_amt = '0;
        w_fun = 2'b00;
        w_ill = 1'b0;
        case (bus.in_funct)
            6'b000000: begin w_fun = 2'b00; w_amt = bus.in_shamt;             end
            6'b000010: begin w_fun = 2'b01; w_amt = bus.in_shamt;             end
            6'b000011: begin w_fun = 2'b11; w_amt = bus.in_shamt;             end
            6'b000100: begin w_fun = 2'b00; w_amt = bus.in_rs[SHAMT_W-1:0];   end
            6'b000110: begin w_fun = 2'b01; w_amt = bus.in_rs[SHAMT_W-1:0];   end
            6'b000111: begin w_fun = 2'b11; w_amt = bus.in_rs[SHAMT_W-1:0];   end
            default:   begin w_fun = 2'b00; w_amt = '0; w_ill = 1'b1;         end
        endcase
    end

    assign w_b = {{(WIDTH-SHAMT_W){1'b0}}, w_amt};

    // Flush overrides both handshakes; state bit 1 is the skid-valid flag.
    assign w_accept = bus.in_valid  & ~r_state[1] & ~bus.flush;
    assign w_xfer   = bus.out_ready &  r_state[0] & ~bus.flush;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (bus.flush) begin
            w_state_nxt = c_ST_EMPTY;
        end else begin
            case (r_state)
                c_ST_EMPTY: if (w_accept) w_state_nxt = c_ST_ONE;
                c_ST_ONE: begin
                    if (w_accept && !w_xfer)      w_state_nxt = c_ST_FULL;
                    else if (!w_accept && w_xfer) w_state_nxt = c_ST_EMPTY;
                end
                c_ST_FULL:  if (w_xfer) w_state_nxt = c_ST_ONE;
                default:    w_state_nxt = c_ST_EMPTY;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs and datapath steering
    // ------------------------------------------------------------------
    always_comb begin
        w_in_ready     = ~r_state[1];
        w_out_valid    =  r_state[0];
        w_load_main    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;
        case (r_state)
            c_ST_EMPTY: w_load_main = w_accept;
            c_ST_ONE: begin
                w_load_main = w_accept &  w_xfer;
                w_load_skid = w_accept & ~w_xfer;
            end
            c_ST_FULL:  w_skid_to_main = w_xfer;
            default: begin
                w_in_ready  = 1'b1;
                w_out_valid = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Main and skid entry storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_a   <= '0;
            r_main_b   <= '0;
            r_main_fun <= 2'b00;
            r_main_ill <= 1'b0;
            r_skid_a   <= '0;
            r_skid_b   <= '0;
            r_skid_fun <= 2'b00;
            r_skid_ill <= 1'b0;
        end else begin
            if (w_load_main) begin
                r_main_a   <= bus.in_rt;
                r_main_b   <= w_b;
                r_main_fun <= w_fun;
                r_main_ill <= w_ill;
            end else if (w_skid_to_main) begin
                r_main_a   <= r_skid_a;
                r_main_b   <= r_skid_b;
                r_main_fun <= r_skid_fun;
                r_main_ill <= r_skid_ill;
            end
            if (w_load_skid) begin
                r_skid_a   <= bus.in_rt;
                r_skid_b   <= w_b;
                r_skid_fun <= w_fun;
                r_skid_ill <= w_ill;
            end
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = w_out_valid;
    assign bus.out_a       = r_main_a;
    assign bus.out_b       = r_main_b;
    assign bus.out_alufun  = r_main_fun;
    assign bus.out_illegal = r_main_ill;

`ifdef SHIFT_STALL_CNT_EN
    // Saturating count of cycles the EX stage held off a valid operation.
    logic [31:0] r_stall_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_out_valid && !bus.out_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end
    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: doc/shift_operand_stage.md
Name: shift_operand_stage

Overview:
- EX-stage front end for the barrel shifter. It registers the shift instruction operands coming out of decode and decodes the R-type funct field into the shifter's 2-bit shift-type code.
- It selects the shift amount: immediate shamt for sll/srl/sra, rs[4:0] for sllv/srlv/srav.
- Its output drives the shifter's a, b and alufun inputs directly.
- A 2-entry skid buffer with valid/ready handshakes decouples decode from EX back-pressure.

Parameters:
- WIDTH, 32, operand data width.
- SHAMT_W, 5, shift-amount width; out_b is the amount zero-extended to WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous pipeline flush; discards all held entries
- in_valid  input  1  decode presents an operation
- in_ready  output  1  stage can accept an operation this cycle
- in_funct  input  6  R-type funct field
- in_shamt  input  SHAMT_W  instruction shamt field
- in_rs  input  WIDTH  rs register value
- in_rt  input  WIDTH  rt register value (data to be shifted)
- out_valid  output  1  out_* fields hold a valid operation
- out_ready  input  1  EX stage consumes the operation
- out_a  output  WIDTH  shifter data input (rt)
- out_b  output  WIDTH  shifter amount, zero-extended
- out_alufun  output  2  00 = sll, 01 = srl, 11 = sra
- out_illegal  output  1  funct is not a shift; pass-through with amount 0

Behaviour:
- Reset (rst_n low, asynchronous):
  - Both entries are invalid.
  - out_valid = 0, in_ready = 1.
  - out_a, out_b, out_alufun and out_illegal all read 0.
- Decode (combinational on input, stored on accept):
  - funct 000000 → sll: alufun 00, amount = in_shamt.
  - funct 000010 → srl: alufun 01, amount = in_shamt.
  - funct 000011 → sra: alufun 11, amount = in_shamt.
  - funct 000100 → sllv: alufun 00, amount = in_rs[4:0].
  - funct 000110 → srlv: alufun 01, amount = in_rs[4:0].
  - funct 000111 → srav: alufun 11, amount = in_rs[4:0].
  - Any other funct → alufun 00, amount 0, illegal = 1.
  - In all cases a = in_rt and b = {WIDTH-SHAMT_W zeros, amount}. in_rs bits [31:5] are ignored.
- Handshake:
  - Accept occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - Inputs must stay stable while in_valid=1 and in_ready=0. out_* stay stable while out_valid=1 and out_ready=0.
- States (main valid M, skid valid S):
  - EMPTY (M=0, S=0):
    - accept → ONE.
  - ONE (M=1, S=0):
    - accept with no transfer → FULL; the new operation goes to skid.
    - accept with transfer → ONE; main is reloaded with the new operation.
    - transfer with no accept → EMPTY.
  - FULL (M=1, S=1):
    - in_ready = 0.
    - transfer → ONE; skid moves to main.
    - No accept is possible in this state.
- in_ready is registered: in_ready = ~S. Full throughput is 1 op/cycle.
- Latency: an operation accepted in cycle N is presented on out_* in cycle N+1.
- Ordering is strict FIFO; no operation is dropped or duplicated.
- Flush:
  - Next state is EMPTY, regardless of in_valid or out_ready in that cycle.
  - An input offered in the flush cycle is discarded.
  - Flush has priority over accept and transfer.
- Reset asserted mid-operation immediately clears both entries; no partial transfer.

Optional Feature:
SHIFT_STALL_CNT_EN
- Defined:
  - Adds output port stall_cnt [31:0].
  - The counter increments on every cycle with out_valid=1 and out_ready=0.
  - It saturates at 32'hFFFFFFFF.
  - It clears on rst_n only; flush does not clear it.
- Undefined: the port and counter do not exist. Datapath behaviour is identical either way.

Test Plan:
- Reset, then sll: funct 000000, shamt 4, rt 32'h0000_00F1, out_ready=1 → next cycle out_valid=1, out_a=32'h0000_00F1, out_b=32'h4, out_alufun=00, out_illegal=0.
- srav: funct 000111, rs 32'hFFFF_FFE3, rt 32'h8000_0000 → out_b=32'h3 (upper rs bits ignored), out_alufun=11, out_a=32'h8000_0000.
- Back-pressure: hold out_ready=0 and offer ops A, B, C on consecutive cycles → A and B accepted, in_ready=0 from the cycle after B, C held. Raise out_ready → A, B, C emerge in order with no loss.
- Flush while FULL with in_valid=1 → next cycle out_valid=0, in_ready=1. The offered op never appears at the output.
- Illegal funct 100000 → out_illegal=1, out_b=0, out_alufun=00, out_a=in_rt.
- rst_n pulsed low while out_valid=1 → out_valid drops asynchronously. With SHIFT_STALL_CNT_EN defined, 7 stall cycles → stall_cnt=7, and the count resets to 0 on rst_n.
